// File: rtl/fpga_test_step_mul_pipe_hs.sv
// fpga_test_step_mul_pipe_hs: pipelined multiplier with valid/ready handshake.
// The multiply sits in the first stage; the remaining stages are plain retiming
// registers so synthesis can pull them into the DSP pipeline.
// Optional feature macro: MUL_PIPE_SAT_EN (clamp dout to the result range and
// raise dout_ovf instead of wrapping; the clamp lives in the final stage).
module fpga_test_step_mul_pipe_hs #(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 3,
  parameter int din0_WIDTH  = 30,
  parameter int din1_WIDTH  = 29,
  parameter int dout_WIDTH  = 58,
  parameter int DIN0_SIGNED = 1,
  parameter int DIN1_SIGNED = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  dout_ovf,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int A_W = din0_WIDTH + 1;
  localparam int B_W = din1_WIDTH + 1;
  localparam int P_W = A_W + B_W;
  localparam bit R_SIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);

  if (NUM_STAGE < 1 || NUM_STAGE > 8) begin : g_bad_stage
    $error("fpga_test_step_mul_pipe_hs ID=%0d: NUM_STAGE=%0d outside 1..8", ID, NUM_STAGE);
  end

  logic                  ce;
  logic [A_W-1:0]        a_ext;
  logic [B_W-1:0]        b_ext;
  logic [P_W-1:0]        a_full;
  logic [P_W-1:0]        b_full;
  logic [P_W-1:0]        prod;
  logic [P_W-1:0]        last_prod;
  logic [dout_WIDTH-1:0] wrap_val;
  logic [dout_WIDTH-1:0] final_val;
  logic                  final_ovf;
  logic [NUM_STAGE-1:0]  valid_d, valid_q;
  logic [dout_WIDTH-1:0] dout_d, dout_q;
  logic                  ovf_d, ovf_q;

  // Whole pipeline freezes only when the output slot is full and not drained.
  assign ce        = !valid_q[NUM_STAGE-1] | out_ready;
  assign in_ready  = ce;
  assign out_valid = valid_q[NUM_STAGE-1];
  assign dout      = dout_q;
  assign dout_ovf  = ovf_q;

  // Extend each operand by one bit, then to full product width; the low P_W
  // bits of a same-width multiply are the exact two's complement product.
  always_comb begin
    a_ext  = {((DIN0_SIGNED != 0) ? din0[din0_WIDTH-1] : 1'b0), din0};
    b_ext  = {((DIN1_SIGNED != 0) ? din1[din1_WIDTH-1] : 1'b0), din1};
    a_full = {{(P_W-A_W){a_ext[A_W-1]}}, a_ext};
    b_full = {{(P_W-B_W){b_ext[B_W-1]}}, b_ext};
    prod   = a_full * b_full;
  end

  if (NUM_STAGE == 1) begin : g_direct
    assign last_prod = prod;
  end else begin : g_mid
    logic [P_W-1:0] mid_d [NUM_STAGE-1];
    logic [P_W-1:0] mid_q [NUM_STAGE-1];

    // Product capture plus retiming shift, frozen when stalled.
    always_comb begin
      mid_d = mid_q;
      if (ce) begin
        mid_d[0] = prod;
        for (int i = 1; i < NUM_STAGE - 1; i++) mid_d[i] = mid_q[i-1];
      end
    end

    // Retiming registers; reset clears in-flight data.
    always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
        for (int i = 0; i < NUM_STAGE - 1; i++) mid_q[i] <= '0;
      end else begin
        mid_q <= mid_d;
      end
    end

    assign last_prod = mid_q[NUM_STAGE-2];
  end

  // Wrapped result: truncation, or sign extension (unsigned products are
  // non-negative in P_W bits, so sign extension also zero-extends them).
  if (dout_WIDTH < P_W) begin : g_wrap_narrow
    assign wrap_val = last_prod[dout_WIDTH-1:0];
  end else if (dout_WIDTH == P_W) begin : g_wrap_equal
    assign wrap_val = last_prod;
  end else begin : g_wrap_wide
    assign wrap_val = {{(dout_WIDTH-P_W){last_prod[P_W-1]}}, last_prod};
  end

`ifdef MUL_PIPE_SAT_EN
  logic                  ovf_hit;
  logic [dout_WIDTH-1:0] sat_val;

  if (dout_WIDTH >= P_W) begin : g_sat_none
    assign ovf_hit = 1'b0;
    assign sat_val = wrap_val;
  end else if (R_SIGNED) begin : g_sat_signed
    // In range only if every bit from the dout sign bit upward agrees.
    assign ovf_hit = !(&last_prod[P_W-1:dout_WIDTH-1]) && (|last_prod[P_W-1:dout_WIDTH-1]);
    assign sat_val = last_prod[P_W-1] ? {1'b1, {(dout_WIDTH-1){1'b0}}}
                                      : {1'b0, {(dout_WIDTH-1){1'b1}}};
  end else begin : g_sat_unsigned
    assign ovf_hit = |last_prod[P_W-1:dout_WIDTH];
    assign sat_val = {dout_WIDTH{1'b1}};
  end

  assign final_val = ovf_hit ? sat_val : wrap_val;
  assign final_ovf = ovf_hit;
`else
  assign final_val = wrap_val;
  assign final_ovf = 1'b0;
`endif

  // Valid shift and output stage, all advancing together on ce.
  always_comb begin
    valid_d = valid_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q;
    if (ce) begin
      valid_d[0] = in_valid;
      for (int i = 1; i < NUM_STAGE; i++) valid_d[i] = valid_q[i-1];
      dout_d = final_val;
      ovf_d  = final_ovf;
    end
  end

  // Output and valid registers; reset discards everything in flight.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      valid_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fpga_test_step_mul_pipe_hs.sv
// Directed bench for fpga_test_step_mul_pipe_hs: default instance plus a
// narrow signed instance and a single-stage unsigned instance.
module tb_fpga_test_step_mul_pipe_hs;

  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default instance
  logic [29:0] din0;
  logic [28:0] din1;
  logic        in_valid, in_ready, out_valid, out_ready, dout_ovf;
  logic [57:0] dout;

  fpga_test_step_mul_pipe_hs u_dut (
    .ap_clk(clk), .ap_rst(rst), .din0(din0), .din1(din1),
    .in_valid(in_valid), .in_ready(in_ready), .dout(dout), .dout_ovf(dout_ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  // 16x16 signed -> 16
  logic [15:0] n_din0, n_din1, n_dout;
  logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_dout_ovf;

  fpga_test_step_mul_pipe_hs #(
    .ID(2), .NUM_STAGE(3), .din0_WIDTH(16), .din1_WIDTH(16), .dout_WIDTH(16),
    .DIN0_SIGNED(1), .DIN1_SIGNED(1)
  ) u_narrow (
    .ap_clk(clk), .ap_rst(rst), .din0(n_din0), .din1(n_din1),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .dout(n_dout), .dout_ovf(n_dout_ovf),
    .out_valid(n_out_valid), .out_ready(n_out_ready)
  );

  // 8x8 unsigned -> 16, single stage
  logic [7:0]  u_din0, u_din1;
  logic [15:0] u_dout;
  logic        u_in_valid, u_in_ready, u_out_valid, u_out_ready, u_dout_ovf;

  fpga_test_step_mul_pipe_hs #(
    .ID(3), .NUM_STAGE(1), .din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(16),
    .DIN0_SIGNED(0), .DIN1_SIGNED(0)
  ) u_uns (
    .ap_clk(clk), .ap_rst(rst), .din0(u_din0), .din1(u_din1),
    .in_valid(u_in_valid), .in_ready(u_in_ready), .dout(u_dout), .dout_ovf(u_dout_ovf),
    .out_valid(u_out_valid), .out_ready(u_out_ready)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (dout !== 58'd0) begin bad++; $display("FAIL reset_dout: got %h want 0", dout); end
    total++; if (dout_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", dout_ovf); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (n_out_valid !== 1'b0 || u_out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_other_valid: got %b%b want 00", n_out_valid, u_out_valid);
    end
  endtask

  task automatic test_basic();
    int n;
    @(negedge clk);
    din0 = -30'sd3; din1 = 29'd5; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk); in_valid = 1'b0; #1;
    end while (!out_valid && n < 20);
    total++; if (n != 3) begin bad++; $display("FAIL basic_latency: got %0d want 3", n); end
    total++; if (dout !== -58'sd15) begin bad++; $display("FAIL basic_dout: got %h want %h", dout, -58'sd15); end
    total++; if (dout_ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf: got %b want 0", dout_ovf); end
    @(posedge clk);
  endtask

  task automatic test_extremes();
    int n;
    logic [57:0] exp_d;
    logic        exp_o;
    // -2^29 * (2^29-1) = -(2^58-2^29); its low 58 bits are 2^29
`ifdef MUL_PIPE_SAT_EN
    exp_d = {1'b1, 57'd0}; exp_o = 1'b1;
`else
    exp_d = 58'h0000_0000_2000_0000; exp_o = 1'b0;
`endif
    @(negedge clk);
    din0 = 30'h2000_0000; din1 = 29'h1FFF_FFFF; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk); in_valid = 1'b0; #1;
    end while (!out_valid && n < 20);
    total++; if (n != 3) begin bad++; $display("FAIL ext_latency: got %0d want 3", n); end
    total++; if (dout !== exp_d) begin bad++; $display("FAIL ext_dout: got %h want %h", dout, exp_d); end
    total++; if (dout_ovf !== exp_o) begin bad++; $display("FAIL ext_ovf: got %b want %b", dout_ovf, exp_o); end
    @(posedge clk);
  endtask

  task automatic test_back_to_back();
    logic signed [29:0] t0 [10];
    logic        [28:0] t1 [10];
    logic signed [57:0] ex [10];
    int i, k, extra;
    logic stalled_prev;
    logic [57:0] held;
    bit in_x, out_x;
    t0 = '{30'sd1, -30'sd1, 30'sd100, -30'sd100, 30'sd12345, -30'sd7, 30'sd0, 30'sd65535, -30'sd32768, 30'sd3};
    t1 = '{29'd1, 29'd1, 29'd3, 29'd3, 29'd2, 29'd9, 29'd99, 29'd2, 29'd4, 29'd1000};
    ex = '{58'sd1, -58'sd1, 58'sd300, -58'sd300, 58'sd24690, -58'sd63, 58'sd0, 58'sd131070, -58'sd131072, 58'sd3000};
    i = 0; k = 0; stalled_prev = 1'b0; held = '0;
    for (int c = 0; c < 60 && k < 10; c++) begin
      @(negedge clk);
      out_ready = !(c >= 4 && c <= 7);
      if (i < 10) begin in_valid = 1'b1; din0 = t0[i]; din1 = t1[i]; end
      else in_valid = 1'b0;
      #1;
      if (stalled_prev) begin
        total++; if (out_valid !== 1'b1 || dout !== held) begin
          bad++; $display("FAIL b2b_hold c=%0d: got v=%b d=%h want v=1 d=%h", c, out_valid, dout, held);
        end
      end
      if (out_valid && !out_ready) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall_ready c=%0d: got %b want 0", c, in_ready); end
        stalled_prev = 1'b1; held = dout;
      end else stalled_prev = 1'b0;
      in_x  = in_valid && in_ready;
      out_x = out_valid && out_ready;
      if (out_x) begin
        total++; if (dout !== ex[k]) begin bad++; $display("FAIL b2b_data k=%0d: got %h want %h", k, dout, ex[k]); end
        k++;
      end
      if (in_x) i++;
    end
    total++; if (k != 10) begin bad++; $display("FAIL b2b_count: got %0d want 10", k); end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      #1; if (out_valid) extra++;
      @(negedge clk);
    end
    total++; if (extra != 0) begin bad++; $display("FAIL b2b_duplicate: got %0d extra want 0", extra); end
  endtask

  task automatic test_reset_flush();
    int seen;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; din0 = 30'd7; din1 = 29'd7;
    @(negedge clk);
    din0 = 30'd9; din1 = 29'd9;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    total++; if (dout !== 58'd0) begin bad++; $display("FAIL flush_dout: got %h want 0", dout); end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      if (out_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL flush_ghost: got %0d outputs want 0", seen); end
  endtask

  task automatic test_narrow();
    logic [15:0] a [3];
    logic [15:0] b [3];
    logic [15:0] ed [3];
    logic        eo [3];
    int n;
    a = '{16'd30000, -16'sd30000, -16'sd100};
    b = '{16'd4, 16'd4, 16'd3};
`ifdef MUL_PIPE_SAT_EN
    ed = '{16'h7FFF, 16'h8000, 16'hFED4};
    eo = '{1'b1, 1'b1, 1'b0};
`else
    ed = '{16'hD4C0, 16'h2B40, 16'hFED4};
    eo = '{1'b0, 1'b0, 1'b0};
`endif
    n_out_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      @(negedge clk);
      n_din0 = a[v]; n_din1 = b[v]; n_in_valid = 1'b1;
      n = 0;
      do begin
        @(posedge clk); n++;
        @(negedge clk); n_in_valid = 1'b0; #1;
      end while (!n_out_valid && n < 20);
      total++; if (n != 3) begin bad++; $display("FAIL narrow_latency v=%0d: got %0d want 3", v, n); end
      total++; if (n_dout !== ed[v]) begin bad++; $display("FAIL narrow_dout v=%0d: got %h want %h", v, n_dout, ed[v]); end
      total++; if (n_dout_ovf !== eo[v]) begin bad++; $display("FAIL narrow_ovf v=%0d: got %b want %b", v, n_dout_ovf, eo[v]); end
    end
  endtask

  task automatic test_unsigned_single();
    logic [7:0]  a [2];
    logic [7:0]  b [2];
    logic [15:0] ed [2];
    a = '{8'hFF, 8'd200};
    b = '{8'hFF, 8'd3};
    ed = '{16'hFE01, 16'h0258};
    u_out_ready = 1'b1;
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      u_din0 = a[v]; u_din1 = b[v]; u_in_valid = 1'b1;
      @(negedge clk);
      u_in_valid = 1'b0; #1;
      total++; if (u_out_valid !== 1'b1) begin bad++; $display("FAIL uns_valid v=%0d: got %b want 1", v, u_out_valid); end
      total++; if (u_dout !== ed[v]) begin bad++; $display("FAIL uns_dout v=%0d: got %h want %h", v, u_dout, ed[v]); end
      total++; if (u_dout_ovf !== 1'b0) begin bad++; $display("FAIL uns_ovf v=%0d: got %b want 0", v, u_dout_ovf); end
      @(negedge clk); #1;
      total++; if (u_out_valid !== 1'b0) begin bad++; $display("FAIL uns_bubble v=%0d: got %b want 0", v, u_out_valid); end
    end
  endtask

  initial begin
    din0 = '0; din1 = '0; in_valid = 1'b0; out_ready = 1'b1;
    n_din0 = '0; n_din1 = '0; n_in_valid = 1'b0; n_out_ready = 1'b1;
    u_din0 = '0; u_din1 = '0; u_in_valid = 1'b0; u_out_ready = 1'b1;
    test_reset();
    test_basic();
    test_extremes();
    test_back_to_back();
    test_reset_flush();
    test_narrow();
    test_unsigned_single();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
